// File: rtl/gcd_pkg.sv
// ============================================================================
// Module   : gcd_pkg
// Brief    : Shared state encoding and default sizing for the GCD host feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gcd_pkg;

    localparam int GCD_WIDTH   = 16;
    localparam int GCD_TIMEOUT = 1023;

    typedef logic [2:0] gcd_state_t;

    localparam logic [2:0] GCD_IDLE   = 3'd0;
    localparam logic [2:0] GCD_LOAD_A = 3'd1;
    localparam logic [2:0] GCD_LOAD_B = 3'd2;
    localparam logic [2:0] GCD_WAIT   = 3'd3;
    localparam logic [2:0] GCD_RESP   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/gcd_timeout_ctr.sv
// ============================================================================
// Module   : gcd_timeout_ctr
// Brief    : Loadable up-counter with clear, enable and terminal-count flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gcd_timeout_ctr #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign o_tc = (count_q == C_TERMINAL);

    // Counting stops at terminal count so the flag stays asserted.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = i_load_val;
        end else if (i_en && !o_tc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gcd_host_feeder.sv
// ============================================================================
// Module   : gcd_host_feeder
// Brief    : Host-side sequencer feeding operand pairs to a subtractive GCD core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gcd_host_feeder
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_err,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rsp_gcd_q, rsp_gcd_d;
    logic             rsp_err_q, rsp_err_d;
    logic             ctr_clr;
    logic             ctr_en;
    logic             ctr_tc;

    gcd_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (ctr_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (ctr_en),
        .o_tc       (ctr_tc)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rsp_gcd_d = rsp_gcd_q;
        rsp_err_d = rsp_err_q;
        ctr_clr   = 1'b0;
        ctr_en    = 1'b0;
        case (state_q)
            GCD_IDLE: begin
                if (req_valid) begin
                    a_d = req_a;
                    b_d = req_b;
                    // A zero operand would never terminate a subtractive GCD.
                    if ((req_a == '0) || (req_b == '0)) begin
                        rsp_gcd_d = (req_a == '0) ? req_b : req_a;
                        rsp_err_d = 1'b1;
                        state_d   = GCD_RESP;
                    end else begin
                        state_d   = GCD_LOAD_A;
                    end
                end
            end
            GCD_LOAD_A: state_d = GCD_LOAD_B;
            GCD_LOAD_B: begin
                ctr_clr = 1'b1;
                state_d = GCD_WAIT;
            end
            GCD_WAIT: begin
                if (gcd_done) begin
                    rsp_gcd_d = gcd_result;
                    rsp_err_d = 1'b0;
                    state_d   = GCD_RESP;
                end else if (ctr_tc) begin
                    rsp_gcd_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = GCD_RESP;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            GCD_RESP: begin
                if (rsp_ready) begin
                    state_d = GCD_IDLE;
                end
            end
            default: state_d = GCD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= GCD_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rsp_gcd_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rsp_gcd_q <= rsp_gcd_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign req_ready = (state_q == GCD_IDLE);
    assign rsp_valid = (state_q == GCD_RESP);
    assign gcd_start = (state_q == GCD_LOAD_A) || (state_q == GCD_LOAD_B) ||
                       (state_q == GCD_WAIT);
    assign gcd_data  = (state_q == GCD_LOAD_A) ? a_q :
                       ((state_q == GCD_LOAD_B) || (state_q == GCD_WAIT)) ? b_q : '0;
    assign rsp_gcd   = rsp_gcd_q;
    assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_host_feeder.sv
// ============================================================================
// Module   : tb_gcd_host_feeder
// Brief    : Self-checking bench for gcd_host_feeder with a behavioural core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gcd_host_feeder;

    localparam int W  = 16;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_gcd;
    logic         rsp_err;
    logic         gcd_start;
    logic [W-1:0] gcd_data;
    logic         gcd_done = 1'b0;
    logic [W-1:0] gcd_result = '0;

    int pass_cnt = 0;
    int total_cnt = 0;

    gcd_host_feeder #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_gcd    (rsp_gcd),
        .rsp_err    (rsp_err),
        .gcd_start  (gcd_start),
        .gcd_data   (gcd_data),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        int x = a;
        int y = b;
        while (y != 0) begin
            int t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    // done_cyc: WAIT cycle (1-based) in which the core raises done; 0 = never.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int done_cyc, input int hold,
                           input logic [W-1:0] exp_gcd, input logic exp_err,
                           input bit glitch);
        logic [W-1:0] core_val;
        int  first;
        int  exp_first;
        bit  bus_ok;
        bit  stable;
        core_val = gcd_ref(a, b);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        rsp_ready = 1'b0;
        if (glitch) begin
            gcd_done = 1'b1;
            gcd_result = W'($urandom);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = W'($urandom);
        req_b = W'($urandom);
        if ((a == 0) || (b == 0)) begin
            chk("bypass_no_start", gcd_start, 0);
            chk("bypass_rsp_valid", rsp_valid, 1);
        end else begin
            chk("load_a_start", gcd_start, 1);
            chk("load_a_data", gcd_data, a);
            chk("load_a_req_ready", req_ready, 0);
            @(posedge clk); #1;
            chk("load_b_data", gcd_data, b);
            chk("load_b_start", gcd_start, 1);
            @(posedge clk); #1;
            first = 0;
            bus_ok = 1'b1;
            for (int idx = 1; idx <= TO + 3; idx++) begin
                if (first == 0) begin
                    if (rsp_valid) begin
                        first = idx;
                    end else begin
                        if (!(gcd_start && gcd_data == b && !req_ready)) bus_ok = 1'b0;
                        gcd_done = (idx == done_cyc);
                        gcd_result = gcd_done ? core_val : W'($urandom);
                        @(posedge clk); #1;
                    end
                end
            end
            gcd_done = glitch;
            exp_first = (done_cyc != 0) ? done_cyc + 1 : TO + 1;
            chk("wait_bus_held", bus_ok, 1);
            chk("rsp_latency", first, exp_first);
        end
        chk("rsp_gcd", rsp_gcd, exp_gcd);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_start_low", gcd_start, 0);
        chk("rsp_data_zero", gcd_data, 0);
        if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (!(rsp_valid && !req_ready && !gcd_start &&
                      rsp_gcd == exp_gcd && rsp_err == exp_err)) stable = 1'b0;
            end
            chk("rsp_hold_stable", stable, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        gcd_done = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_rsp_req_ready", req_ready, 1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           done_cyc;
        int           hold;
        logic [W-1:0] exp_gcd;
        logic         exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [W-1:0] ra, rb, eg;
        logic         ee;
        int           dc;
        bit           quiet;

        vecs[0] = '{16'd143,   16'd78,  5, 0, 16'd13,    1'b0};
        vecs[1] = '{16'd48,    16'd0,   0, 2, 16'd48,    1'b1};
        vecs[2] = '{16'd0,     16'd0,   0, 0, 16'd0,     1'b1};
        vecs[3] = '{16'd0,     16'd35,  0, 0, 16'd35,    1'b1};
        vecs[4] = '{16'd9,     16'd6,   0, 1, 16'd0,     1'b1};
        vecs[5] = '{16'd36,    16'd24,  4, 5, 16'd12,    1'b0};
        vecs[6] = '{16'd17,    16'd5,   2, 0, 16'd1,     1'b0};
        vecs[7] = '{16'd21,    16'd14,  8, 0, 16'd7,     1'b0};
        vecs[8] = '{16'd100,   16'd75,  1, 0, 16'd25,    1'b0};
        vecs[9] = '{16'd65535, 16'd1,   3, 0, 16'd1,     1'b0};

        #2;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_gcd", rsp_gcd, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_gcd_start", gcd_start, 0);
        chk("reset_gcd_data", gcd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].done_cyc, vecs[i].hold,
                    vecs[i].exp_gcd, vecs[i].exp_err, 1'b0);
        end

        // Reset pulsed while waiting on the core for (100,75).
        req_valid = 1'b1;
        req_a = 16'd100;
        req_b = 16'd75;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_rsp_gcd", rsp_gcd, 0);
        chk("midrst_rsp_err", rsp_err, 0);
        chk("midrst_gcd_start", gcd_start, 0);
        chk("midrst_gcd_data", gcd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (TO + 2) begin
            @(posedge clk); #1;
            if (rsp_valid || gcd_start || !req_ready) quiet = 1'b0;
        end
        chk("midrst_no_response", quiet, 1);
        run_txn(16'd100, 16'd75, 3, 0, 16'd25, 1'b0, 1'b0);

        // Randomized traffic against the rule-level model.
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 9) == 0) ? '0 :
                 ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 60)) : W'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? '0 :
                 ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 60)) : W'($urandom);
            dc = $urandom_range(0, TO);
            if ((ra == 0) || (rb == 0)) begin
                eg = (ra == 0) ? rb : ra;
                ee = 1'b1;
            end else if (dc == 0) begin
                eg = '0;
                ee = 1'b1;
            end else begin
                eg = gcd_ref(ra, rb);
                ee = 1'b0;
            end
            run_txn(ra, rb, dc, $urandom_range(0, 3), eg, ee, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gcd_host_feeder.md
# gcd_host_feeder

Initiator-side sequencer for the GCD datapath/controller pair. Accepts an operand pair from a host over a valid/ready handshake and asserts `gcd_start`. It then drives operand A and operand B on consecutive cycles onto the shared 16-bit `gcd_data` bus, waits for `gcd_done`, and returns the result through a second valid/ready handshake. It also guards the GCD core against the two conditions that hang a subtractive GCD: zero operands and runaway iteration.

## Interface
- `WIDTH`, 16: operand and result width.
- `TIMEOUT`, 1023: maximum cycles spent in WAIT before aborting. Must be at least 1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: host presents an operand pair.
- `req_ready` output 1: feeder can accept a pair. Asserted only in IDLE.
- `req_a` input WIDTH: operand A.
- `req_b` input WIDTH: operand B.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: host accepts the result.
- `rsp_gcd` output WIDTH: GCD result.
- `rsp_err` output 1: 1 means the zero-operand or timeout path was taken.
- `gcd_start` output 1: start strobe to the GCD controller.
- `gcd_data` output WIDTH: shared operand bus to the GCD datapath.
- `gcd_done` input 1: GCD controller completion.
- `gcd_result` input WIDTH: GCD datapath A-register output. Sampled when `gcd_done` is high.

## Operation
- States: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - When `req_valid`=1, latch `req_a` and `req_b`.
  - If either latched operand is 0, go directly to RESP with the bypass result. `gcd_start` is never asserted on this path.
  - Otherwise go to LOAD_A.
- **LOAD_A**: `gcd_start`=1, `gcd_data`=A. Go to LOAD_B.
- **LOAD_B**: `gcd_start`=1, `gcd_data`=B. Go to WAIT and clear the timeout counter.
- **WAIT**
  - `gcd_start`=1, `gcd_data`=B (held).
  - If `gcd_done`=1: capture `gcd_result` into `rsp_gcd`, set `rsp_err`=0, go to RESP.
  - Else if the counter equals TIMEOUT-1: set `rsp_gcd`=0, `rsp_err`=1, go to RESP.
  - Otherwise increment the counter.
- **RESP**
  - `rsp_valid`=1 and `gcd_start`=0.
  - Go to IDLE on `rsp_valid && rsp_ready`.
  - `rsp_gcd` and `rsp_err` are held stable while `rsp_ready` is low.
- Zero-operand bypass results:
  - gcd(a,0) = a with `rsp_err`=1.
  - gcd(0,b) = b with `rsp_err`=1.
  - gcd(0,0) = 0 with `rsp_err`=1.
- `gcd_done` is ignored outside WAIT. A `gcd_done` still high from a previous run does not complete a new WAIT, because at least one RESP cycle with `gcd_start`=0 separates runs.
- `gcd_data` is 0 in IDLE and RESP.
- Operands are unsigned. No arithmetic is performed beyond the zero compare and the counter. The counter width is clog2(TIMEOUT+1).

## Timing
- **Reset values** (asynchronous assertion, synchronous release):
  - State IDLE.
  - `req_ready`=1, `rsp_valid`=0, `rsp_gcd`=0, `rsp_err`=0.
  - `gcd_start`=0, `gcd_data`=0.
  - Counter 0.
- Accept-to-start: `gcd_start` rises one cycle after the accepting edge.
- Bus sequence: A is on `gcd_data` for exactly one cycle, then B. The GCD controller loads A on the first edge after start and B on the second.
- Result latency: `rsp_valid` rises one cycle after the edge that samples `gcd_done`=1.
- Minimum throughput: 4 cycles plus the GCD compute time per pair, with `rsp_ready` tied high.
- Timeout: `rsp_valid` rises exactly TIMEOUT+1 cycles after entering WAIT if `gcd_done` never arrives.
- `gcd_done` and timeout in the same cycle: `gcd_done` wins, result is valid, `rsp_err`=0.
- Reset mid-operation, from any state:
  - All outputs return to their reset values immediately.
  - `gcd_start` drops, so the GCD controller is released.
  - No response is produced for the aborted request.

## Structure
- A shared package `gcd_pkg` holds:
  - the state encoding (`GCD_IDLE`, `GCD_LOAD_A`, `GCD_LOAD_B`, `GCD_WAIT`, `GCD_RESP`);
  - the default WIDTH;
  - the default TIMEOUT.
- One natural sub-module: `gcd_timeout_ctr`, a loadable counter with clear, enable and terminal-count output.
- The FSM and the operand/result registers live in the top module.

## Test plan
- Accept (143,78) with the real GCD core attached → bus shows 143 then 78 on consecutive cycles; `rsp_gcd`=13, `rsp_err`=0.
- Accept (48,0) → `rsp_gcd`=48, `rsp_err`=1; `gcd_start` stays 0 throughout.
- Accept (0,0) → `rsp_gcd`=0, `rsp_err`=1.
- Stubbed core that never asserts done, TIMEOUT=8 → `rsp_valid` rises 9 cycles after WAIT entry; `rsp_gcd`=0, `rsp_err`=1.
- Back-to-back requests (36,24) then (17,5), with `rsp_ready` held low 5 cycles on the first → response holds 12 stable; `req_ready` stays 0 until handshake; second yields 1.
- `rst_n` pulsed low during WAIT of (100,75) → outputs at reset values immediately; next request (100,75) returns 25.
